// File: rtl/sd_cmd_rx_if.sv
// Bundles the CMD-line sample strobes and the decoded-frame outputs of sd_cmd_rx.
// The bit sampler drives the master side and the command decoder reads it.
interface sd_cmd_rx_if;
    logic        bit_en;
    logic        cmd_in;
    logic        abort;
    logic        busy;
    logic        frame_valid;
    logic        cmd_dir;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;
    logic [6:0]  cmd_crc;
    logic        crc_ok;
    logic        end_ok;
    logic        dir_err;

    modport master (
        output bit_en, cmd_in, abort,
        input  busy, frame_valid, cmd_dir, cmd_index, cmd_arg, cmd_crc,
               crc_ok, end_ok, dir_err
    );

    modport slave (
        input  bit_en, cmd_in, abort,
        output busy, frame_valid, cmd_dir, cmd_index, cmd_arg, cmd_crc,
               crc_ok, end_ok, dir_err
    );
endinterface

// File: rtl/sd_cmd_rx.sv
// Serial receiver / CRC7 checker for 48-bit SD command frames on the CMD line.
// Optional SD_CMD_RX_ERR_CNT_EN adds a saturating err_cnt of bad delivered frames.
module sd_cmd_rx #(
    parameter bit TX_BIT_CHECK = 1'b1,
    parameter bit TX_BIT_EXP   = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    sd_cmd_rx_if.slave bus
`ifdef SD_CMD_RX_ERR_CNT_EN
    ,
    output logic [7:0] err_cnt
`endif
);

    localparam int unsigned PAY_W        = 39;
    localparam int unsigned CRC_W        = 7;
    localparam int unsigned CNT_W        = 6;
    localparam int unsigned IDX_W        = 6;
    localparam int unsigned ARG_W        = 32;
    localparam int unsigned PAY_LAST_CNT = 39;
    localparam int unsigned CRC_LAST_CNT = 46;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PAYLOAD,
        S_CRC,
        S_STOP,
        S_DONE
    } state_e;

    state_e             state_q,    state_d;
    logic [CNT_W-1:0]   cnt_q,      cnt_d;
    logic [PAY_W-1:0]   pay_q,      pay_d;
    logic [CRC_W-1:0]   crc_q,      crc_d;
    logic [CRC_W-1:0]   crc_sr_q,   crc_sr_d;
    logic               end_q,      end_d;
    logic               busy_q,     busy_d;
    logic               fv_q,       fv_d;
    logic               dir_q,      dir_d;
    logic [IDX_W-1:0]   index_q,    index_d;
    logic [ARG_W-1:0]   arg_q,      arg_d;
    logic [CRC_W-1:0]   cmd_crc_q,  cmd_crc_d;
    logic               crc_ok_q,   crc_ok_d;
    logic               end_ok_q,   end_ok_d;
    logic               dir_err_q,  dir_err_d;
    logic               crc_fb;
`ifdef SD_CMD_RX_ERR_CNT_EN
    logic [7:0]         err_cnt_q,  err_cnt_d;
`endif

    // Next-state, datapath and output decode.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pay_d     = pay_q;
        crc_d     = crc_q;
        crc_sr_d  = crc_sr_q;
        end_d     = end_q;
        busy_d    = busy_q;
        fv_d      = 1'b0;
        dir_d     = dir_q;
        index_d   = index_q;
        arg_d     = arg_q;
        cmd_crc_d = cmd_crc_q;
        crc_ok_d  = crc_ok_q;
        end_ok_d  = end_ok_q;
        dir_err_d = dir_err_q;
        crc_fb    = bus.cmd_in ^ crc_q[6];
`ifdef SD_CMD_RX_ERR_CNT_EN
        err_cnt_d = err_cnt_q;
`endif

        if (bus.abort) begin
            // Abort beats everything, including a start bit on the same cycle.
            state_d = S_IDLE;
            busy_d  = 1'b0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (bus.bit_en && !bus.cmd_in) begin
                        state_d = S_PAYLOAD;
                        busy_d  = 1'b1;
                        cnt_d   = CNT_W'(1);
                        crc_d   = '0;
                    end
                end
                S_PAYLOAD: begin
                    if (bus.bit_en) begin
                        pay_d = {pay_q[PAY_W-2:0], bus.cmd_in};
                        crc_d = {crc_q[5:3], crc_q[2] ^ crc_fb, crc_q[1:0], crc_fb};
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(PAY_LAST_CNT)) begin
                            state_d = S_CRC;
                        end
                    end
                end
                S_CRC: begin
                    if (bus.bit_en) begin
                        crc_sr_d = {crc_sr_q[CRC_W-2:0], bus.cmd_in};
                        cnt_d    = cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(CRC_LAST_CNT)) begin
                            state_d = S_STOP;
                        end
                    end
                end
                S_STOP: begin
                    if (bus.bit_en) begin
                        end_d   = bus.cmd_in;
                        state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    // Deliver regardless of CRC, end-bit or direction errors.
                    dir_d     = pay_q[38];
                    index_d   = pay_q[37:32];
                    arg_d     = pay_q[31:0];
                    cmd_crc_d = crc_sr_q;
                    crc_ok_d  = (crc_q == crc_sr_q);
                    end_ok_d  = end_q;
                    dir_err_d = TX_BIT_CHECK && (pay_q[38] != TX_BIT_EXP);
                    fv_d      = 1'b1;
                    busy_d    = 1'b0;
                    cnt_d     = '0;
                    state_d   = S_IDLE;
`ifdef SD_CMD_RX_ERR_CNT_EN
                    if (((crc_q != crc_sr_q) || !end_q) && (err_cnt_q != 8'hFF)) begin
                        err_cnt_d = err_cnt_q + 8'd1;
                    end
`endif
                end
                default: begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            pay_q     <= '0;
            crc_q     <= '0;
            crc_sr_q  <= '0;
            end_q     <= 1'b0;
            busy_q    <= 1'b0;
            fv_q      <= 1'b0;
            dir_q     <= 1'b0;
            index_q   <= '0;
            arg_q     <= '0;
            cmd_crc_q <= '0;
            crc_ok_q  <= 1'b0;
            end_ok_q  <= 1'b0;
            dir_err_q <= 1'b0;
`ifdef SD_CMD_RX_ERR_CNT_EN
            err_cnt_q <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pay_q     <= pay_d;
            crc_q     <= crc_d;
            crc_sr_q  <= crc_sr_d;
            end_q     <= end_d;
            busy_q    <= busy_d;
            fv_q      <= fv_d;
            dir_q     <= dir_d;
            index_q   <= index_d;
            arg_q     <= arg_d;
            cmd_crc_q <= cmd_crc_d;
            crc_ok_q  <= crc_ok_d;
            end_ok_q  <= end_ok_d;
            dir_err_q <= dir_err_d;
`ifdef SD_CMD_RX_ERR_CNT_EN
            err_cnt_q <= err_cnt_d;
`endif
        end
    end

    assign bus.busy        = busy_q;
    assign bus.frame_valid = fv_q;
    assign bus.cmd_dir     = dir_q;
    assign bus.cmd_index   = index_q;
    assign bus.cmd_arg     = arg_q;
    assign bus.cmd_crc     = cmd_crc_q;
    assign bus.crc_ok      = crc_ok_q;
    assign bus.end_ok      = end_ok_q;
    assign bus.dir_err     = dir_err_q;
`ifdef SD_CMD_RX_ERR_CNT_EN
    assign err_cnt         = err_cnt_q;
`endif

endmodule

// File: tb/tb_sd_cmd_rx.sv
// Self-checking bench for sd_cmd_rx: directed frame table, multi-cycle corner cases
// and random frames against a polynomial-division CRC7 reference model.
module tb_sd_cmd_rx;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sd_cmd_rx_if ifc();
`ifdef SD_CMD_RX_ERR_CNT_EN
    logic [7:0] err_cnt;
`endif

    sd_cmd_rx #(.TX_BIT_CHECK(1'b1), .TX_BIT_EXP(1'b1)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (ifc)
`ifdef SD_CMD_RX_ERR_CNT_EN
        ,
        .err_cnt (err_cnt)
`endif
    );

    typedef struct packed {
        logic        dir;
        logic [5:0]  idx;
        logic [31:0] arg;
        logic [6:0]  crc;
        logic        crc_ok;
        logic        end_ok;
        logic        dir_err;
        logic [7:0]  err;
    } rec_t;

    typedef struct {
        string       name;
        logic [47:0] frame;
        int          per;
        rec_t        exp;
    } vec_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    rec_t mon_q[$];
    logic [7:0] err_exp = 8'd0;

    // Capture every delivered frame as seen by the consumer.
    always @(negedge clk) begin
        if (ifc.frame_valid === 1'b1) begin
            rec_t r;
            r.dir     = ifc.cmd_dir;
            r.idx     = ifc.cmd_index;
            r.arg     = ifc.cmd_arg;
            r.crc     = ifc.cmd_crc;
            r.crc_ok  = ifc.crc_ok;
            r.end_ok  = ifc.end_ok;
            r.dir_err = ifc.dir_err;
`ifdef SD_CMD_RX_ERR_CNT_EN
            r.err     = err_cnt;
`else
            r.err     = 8'd0;
`endif
            mon_q.push_back(r);
        end
    end

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    // CRC7 as the remainder of d(x)*x^7 divided by x^7+x^3+1.
    function automatic logic [6:0] ref_crc7(input logic [39:0] d);
        logic [46:0] r;
        r = {d, 7'd0};
        for (int i = 46; i >= 7; i--) begin
            if (r[i]) r[i-:8] = r[i-:8] ^ 8'h89;
        end
        return r[6:0];
    endfunction

    function automatic rec_t model(input logic [47:0] f);
        rec_t e;
        e.dir     = f[46];
        e.idx     = f[45:40];
        e.arg     = f[39:8];
        e.crc     = f[7:1];
        e.crc_ok  = (ref_crc7(f[47:8]) == f[7:1]);
        e.end_ok  = f[0];
        e.dir_err = (f[46] != 1'b1);
        e.err     = 8'd0;
        return e;
    endfunction

    function automatic rec_t mk(input logic dir, input logic [5:0] idx, input logic [31:0] arg,
                                input logic [6:0] crc, input logic ok, input logic eok, input logic de);
        rec_t e;
        e.dir = dir; e.idx = idx; e.arg = arg; e.crc = crc;
        e.crc_ok = ok; e.end_ok = eok; e.dir_err = de; e.err = 8'd0;
        return e;
    endfunction

    task automatic tick(input logic en, input logic b, input logic ab);
        @(posedge clk);
        #1;
        ifc.bit_en = en;
        ifc.cmd_in = b;
        ifc.abort  = ab;
    endtask

    task automatic send_bit(input logic b, input int per);
        for (int i = 1; i < per; i++) tick(1'b0, 1'b1, 1'b0);
        tick(1'b1, b, 1'b0);
    endtask

    task automatic send_bits(input logic [47:0] f, input int from, input int to, input int per);
        for (int i = from; i >= to; i--) send_bit(f[i], per);
    endtask

    // Whole frame followed by one idle-high bit.
    task automatic send_frame(input logic [47:0] f, input int per);
        send_bits(f, 47, 0, per);
        send_bit(1'b1, per);
        tick(1'b0, 1'b1, 1'b0);
    endtask

    task automatic expect_frame(input string tag, input rec_t e);
        rec_t r;
        bit   got;
        got = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (mon_q.size() > 0) begin
                got = 1'b1;
                break;
            end
            @(posedge clk);
        end
        if (!got) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s.timeout: got 0 frame_valid pulses expected 1", tag);
        end else begin
            r = mon_q.pop_front();
            check({tag, ".dir"},     32'(r.dir),     32'(e.dir));
            check({tag, ".index"},   32'(r.idx),     32'(e.idx));
            check({tag, ".arg"},     r.arg,          e.arg);
            check({tag, ".crc"},     32'(r.crc),     32'(e.crc));
            check({tag, ".crc_ok"},  32'(r.crc_ok),  32'(e.crc_ok));
            check({tag, ".end_ok"},  32'(r.end_ok),  32'(e.end_ok));
            check({tag, ".dir_err"}, 32'(r.dir_err), 32'(e.dir_err));
`ifdef SD_CMD_RX_ERR_CNT_EN
            if (!(e.crc_ok && e.end_ok) && err_exp != 8'hFF) err_exp = err_exp + 8'd1;
            check({tag, ".err_cnt"}, 32'(r.err), 32'(err_exp));
`endif
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".busy"},        32'(ifc.busy),        32'd0);
        check({tag, ".frame_valid"}, 32'(ifc.frame_valid), 32'd0);
        check({tag, ".dir"},         32'(ifc.cmd_dir),     32'd0);
        check({tag, ".index"},       32'(ifc.cmd_index),   32'd0);
        check({tag, ".arg"},         ifc.cmd_arg,          32'd0);
        check({tag, ".crc"},         32'(ifc.cmd_crc),     32'd0);
        check({tag, ".crc_ok"},      32'(ifc.crc_ok),      32'd0);
        check({tag, ".end_ok"},      32'(ifc.end_ok),      32'd0);
        check({tag, ".dir_err"},     32'(ifc.dir_err),     32'd0);
`ifdef SD_CMD_RX_ERR_CNT_EN
        check({tag, ".err_cnt"},     32'(err_cnt),         32'd0);
`endif
    endtask

    localparam logic [47:0] CMD0  = 48'h40_00000000_95;
    localparam logic [47:0] CMD8  = 48'h48_000001AA_87;
    localparam logic [47:0] CMD17 = 48'h51_00000000_55;

    vec_t tbl[5];
    rec_t e_cmd0, e_cmd8, e_cmd17;

    initial begin
        e_cmd0  = mk(1'b1, 6'd0,  32'h0,     7'h4A, 1'b1, 1'b1, 1'b0);
        e_cmd8  = mk(1'b1, 6'd8,  32'h1AA,   7'h43, 1'b1, 1'b1, 1'b0);
        e_cmd17 = mk(1'b1, 6'd17, 32'h0,     7'h2A, 1'b1, 1'b1, 1'b0);
        tbl[0] = '{"cmd0",    CMD0,                  4, e_cmd0};
        tbl[1] = '{"bad_crc", 48'h40_00000000_97,    2, mk(1'b1, 6'd0, 32'h0, 7'h4B, 1'b0, 1'b1, 1'b0)};
        tbl[2] = '{"end0",    48'h40_00000000_94,    3, mk(1'b1, 6'd0, 32'h0, 7'h4A, 1'b1, 1'b0, 1'b0)};
        tbl[3] = '{"tx0",     48'h00_00000000_01,    1, mk(1'b0, 6'd0, 32'h0, 7'h00, 1'b1, 1'b1, 1'b1)};
        tbl[4] = '{"cmd8",    CMD8,                  1, e_cmd8};

        ifc.bit_en = 1'b0;
        ifc.cmd_in = 1'b1;
        ifc.abort  = 1'b0;
        rst_n      = 1'b0;
        repeat (3) tick(1'b0, 1'b1, 1'b0);
        @(negedge clk);
        check_zero("reset");
        @(posedge clk); #1; rst_n = 1'b1;

        // Directed frame table.
        foreach (tbl[k]) begin
            send_frame(tbl[k].frame, tbl[k].per);
            expect_frame(tbl[k].name, tbl[k].exp);
            @(negedge clk);
            check({tbl[k].name, ".busy_after"}, 32'(ifc.busy),        32'd0);
            check({tbl[k].name, ".fv_low"},     32'(ifc.frame_valid), 32'd0);
        end

        // Back-to-back frames with a single idle bit between them.
        send_bits(CMD8, 47, 0, 4);
        send_bit(1'b1, 4);
        send_frame(CMD17, 4);
        expect_frame("b2b_cmd8", e_cmd8);
        expect_frame("b2b_cmd17", e_cmd17);

        // Abort after 21 bits of CMD8: no delivery, outputs unchanged.
        send_bits(CMD8, 47, 27, 4);
        @(negedge clk);
        check("abort.busy_before", 32'(ifc.busy), 32'd1);
        tick(1'b1, CMD8[26], 1'b1);
        tick(1'b0, 1'b1, 1'b0);
        @(negedge clk);
        check("abort.busy", 32'(ifc.busy), 32'd0);
        repeat (60) @(posedge clk);
        check("abort.no_pulse", 32'(mon_q.size()), 32'd0);
        check("abort.index_held", 32'(ifc.cmd_index), 32'd17);
        check("abort.crc_held", 32'(ifc.cmd_crc), 32'h2A);
        send_frame(CMD0, 2);
        expect_frame("abort.cmd0", e_cmd0);

        // Abort on the same cycle as a start bit.
        tick(1'b1, 1'b0, 1'b1);
        tick(1'b0, 1'b1, 1'b0);
        @(negedge clk);
        check("abort_start.busy", 32'(ifc.busy), 32'd0);
        send_frame(CMD17, 1);
        expect_frame("abort_start.cmd17", e_cmd17);

        // Reset mid-frame clears everything and drops the frame.
        send_frame(CMD8, 1);
        expect_frame("pre_rst.cmd8", e_cmd8);
        send_bits(CMD17, 47, 22, 2);
        @(posedge clk); #1; rst_n = 1'b0; ifc.bit_en = 1'b0;
        @(posedge clk); #1; rst_n = 1'b1;
        @(negedge clk);
        check_zero("mid_rst");
        err_exp = 8'd0;
        repeat (20) @(posedge clk);
        check("mid_rst.no_pulse", 32'(mon_q.size()), 32'd0);
        send_frame(CMD0, 3);
        expect_frame("mid_rst.cmd0", e_cmd0);

        // Stall bit_en for 50 clocks mid-payload.
        send_bits(CMD8, 47, 20, 2);
        repeat (50) tick(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("stall.busy", 32'(ifc.busy), 32'd1);
        check("stall.no_pulse", 32'(mon_q.size()), 32'd0);
        send_bits(CMD8, 19, 0, 2);
        send_bit(1'b1, 2);
        tick(1'b0, 1'b1, 1'b0);
        expect_frame("stall.cmd8", e_cmd8);

        // Random frames against the reference model.
        for (int n = 0; n < 40; n++) begin
            logic [39:0] h;
            logic [6:0]  c;
            logic [47:0] f;
            h = {1'b0, ($urandom_range(0, 7) != 0), 6'($urandom), 32'($urandom)};
            c = ref_crc7(h);
            if ($urandom_range(0, 3) == 0) c = c ^ 7'(1 << $urandom_range(0, 6));
            f = {h, c, ($urandom_range(0, 5) != 0)};
            send_frame(f, $urandom_range(1, 5));
            expect_frame($sformatf("rand%0d", n), model(f));
        end

`ifdef SD_CMD_RX_ERR_CNT_EN
        // Saturation of the error counter; abort must not clear it.
        for (int n = 0; n < 256; n++) begin
            send_frame(48'h40_00000000_97, 1);
            expect_frame("sat", mk(1'b1, 6'd0, 32'h0, 7'h4B, 1'b0, 1'b1, 1'b0));
        end
        check("sat.err_cnt", 32'(err_cnt), 32'hFF);
        tick(1'b0, 1'b1, 1'b1);
        tick(1'b0, 1'b1, 1'b0);
        @(negedge clk);
        check("sat.after_abort", 32'(err_cnt), 32'hFF);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
